// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared types and constants for the main-memory responder.
//   state_t             responder FSM states
//   ACK_IDLE            ACK_DATA_MEM value meaning "no word presented/requested"
//   DEF_WORDS_PER_LINE  default burst length (must match the L1D line)
//   DEF_OFFSET_BITS     default log2(burst length)
package main_mem_pkg;

  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_OFFSET_BITS    = 3;

  localparam logic [3:0] ACK_IDLE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT,
    SEND,
    ST_REQ,
    DONE
  } state_t;

endpackage

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if: L1D <-> main-memory miss/store handshake bundle.
//   VALID        cache -> mem  request active, held until the transaction completes
//   STORE        cache -> mem  1 = store, 0 = load (sampled with the address)
//   ADDR_DATA    cache -> mem  address word, then store data
//   ACK_ADDR     cache -> mem  address is on ADDR_DATA
//   ACK_DATA_L1  cache -> mem  echo of consumed/sent word index, 4'hF = none
//   READY        mem -> cache  grant
//   RDATA        mem -> cache  data word
//   ACK_DATA_MEM mem -> cache  index of word on RDATA or requested, 4'hF = idle
//   BUSY         mem -> cache  responder not in IDLE
interface main_mem_responder_if;

  logic        VALID;
  logic        STORE;
  logic [31:0] ADDR_DATA;
  logic        ACK_ADDR;
  logic [3:0]  ACK_DATA_L1;
  logic        READY;
  logic [31:0] RDATA;
  logic [3:0]  ACK_DATA_MEM;
  logic        BUSY;

  modport master (
    output VALID, STORE, ADDR_DATA, ACK_ADDR, ACK_DATA_L1,
    input  READY, RDATA, ACK_DATA_MEM, BUSY
  );

  modport slave (
    input  VALID, STORE, ADDR_DATA, ACK_ADDR, ACK_DATA_L1,
    output READY, RDATA, ACK_DATA_MEM, BUSY
  );

endinterface

// File: rtl/main_mem_array.sv
// main_mem_array: single-port synchronous RAM, registered read, write enable.
//   CLK    clock
//   RST    synchronous active-high reset of the read register only
//   en     access enable (read when we=0)
//   we     write enable (requires en)
//   addr   word address
//   wdata  write data
//   rdata  registered read data; holds its value when not reading
// Array contents are not reset; simulation preloads them externally.
module main_mem_array #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge CLK) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: main-memory end of the L1D miss/store protocol.
//   CLK   rising-edge clock
//   RST   synchronous active-high reset
//   bus   main_mem_responder_if.slave handshake bundle
// Loads stream one line word by word after ACCESS_LATENCY cycles; stores
// accept a single write-through word.
// Optional: MAIN_MEM_CRITICAL_WORD_FIRST_EN starts the burst at the requested
// word and wraps within the line; otherwise bursts run 0..WORDS_PER_LINE-1.
//
// state  | meaning
// IDLE   | no request; READY low
// GRANT  | READY high, waiting for the address (ACK_ADDR)
// WAIT   | load access latency countdown
// SEND   | word k on RDATA/ACK_DATA_MEM until the cache echoes k
// ST_REQ | store data requested with ACK_DATA_MEM=0
// DONE   | transaction finished, waiting for VALID to drop
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int OFFSET_BITS    = DEF_OFFSET_BITS,
  parameter int MEM_ADDR_BITS  = 12,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  main_mem_responder_if.slave  bus
);

  localparam int CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(WORDS_PER_LINE - 1);

  state_t                     state;
  logic [MEM_ADDR_BITS-1:0]   addr_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [OFFSET_BITS-1:0]     k_q;
  logic [OFFSET_BITS-1:0]     beats_q;
  logic                       ready_q;
  logic [3:0]                 ack_q;

  logic [MEM_ADDR_BITS-1:0]   base;
  logic [OFFSET_BITS-1:0]     k_first;
  logic [OFFSET_BITS-1:0]     k_next;
  logic                       ack_hit;

  logic                       ram_en;
  logic                       ram_we;
  logic [MEM_ADDR_BITS-1:0]   ram_addr;
  logic [31:0]                ram_rdata;

  assign base    = {addr_q[MEM_ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign k_next  = k_q + 1'b1;
  assign ack_hit = (bus.ACK_DATA_L1 == 4'(k_q));

`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
  assign k_first = addr_q[OFFSET_BITS-1:0];
`else
  assign k_first = '0;
`endif

  // The RAM read is issued on the same edge that updates ACK_DATA_MEM, so the
  // registered read data and its index always change together.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    if (!RST && bus.VALID) begin
      case (state)
        WAIT: begin
          if (cnt_q == '0) begin
            ram_en   = 1'b1;
            ram_addr = base + MEM_ADDR_BITS'(k_first);
          end
        end
        SEND: begin
          if (ack_hit && beats_q != LAST_BEAT) begin
            ram_en   = 1'b1;
            ram_addr = base + MEM_ADDR_BITS'(k_next);
          end
        end
        ST_REQ: begin
          if (bus.ACK_DATA_L1 == 4'h0) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      beats_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= ACK_IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.VALID) begin
            state   <= GRANT;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.VALID) state <= IDLE;
        end
        default: begin
          if (!bus.VALID) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            ack_q   <= ACK_IDLE;
          end else begin
            case (state)
              GRANT: begin
                if (bus.ACK_ADDR) begin
                  addr_q <= bus.ADDR_DATA[MEM_ADDR_BITS-1:0];
                  if (bus.STORE) begin
                    state <= ST_REQ;
                    ack_q <= 4'h0;
                  end else begin
                    state <= WAIT;
                    cnt_q <= CNT_W'(ACCESS_LATENCY - 1);
                  end
                end
              end
              WAIT: begin
                if (cnt_q == '0) begin
                  state   <= SEND;
                  k_q     <= k_first;
                  beats_q <= '0;
                  ack_q   <= 4'(k_first);
                end else begin
                  cnt_q <= cnt_q - 1'b1;
                end
              end
              SEND: begin
                if (ack_hit) begin
                  if (beats_q == LAST_BEAT) begin
                    state   <= DONE;
                    ready_q <= 1'b0;
                    ack_q   <= ACK_IDLE;
                  end else begin
                    k_q     <= k_next;
                    beats_q <= beats_q + 1'b1;
                    ack_q   <= 4'(k_next);
                  end
                end
              end
              ST_REQ: begin
                if (bus.ACK_DATA_L1 == 4'h0) begin
                  state   <= DONE;
                  ready_q <= 1'b0;
                  ack_q   <= ACK_IDLE;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  main_mem_array #(
    .ADDR_BITS (MEM_ADDR_BITS),
    .DATA_BITS (32)
  ) u_array (
    .CLK   (CLK),
    .RST   (RST),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.ADDR_DATA),
    .rdata (ram_rdata)
  );

  assign bus.READY        = ready_q;
  assign bus.RDATA        = ram_rdata;
  assign bus.ACK_DATA_MEM = ack_q;
  assign bus.BUSY         = (state != IDLE);

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder. Expectations follow the build:
// with MAIN_MEM_CRITICAL_WORD_FIRST_EN defined, bursts start at the requested
// word and wrap; otherwise they run 0..7.
module tb_main_mem_responder;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  main_mem_responder_if bus();

  main_mem_responder dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] d  [8];
  logic [3:0]  ix [8];

  function automatic logic [3:0] exp_k(input logic [2:0] start, input int i);
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    logic [2:0] k;
    k = start + 3'(i);
    return {1'b0, k};
`else
    logic [2:0] unused_start;
    unused_start = start;
    return 4'(i);
`endif
  endfunction

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Raise VALID, wait for READY (bounded), then present the address for one edge.
  task automatic start_txn(input logic [31:0] a, input logic st, output bit ok);
    ok = 1'b0;
    bus.VALID = 1'b1;
    bus.STORE = st;
    for (int i = 0; i < 4 && !ok; i++) begin
      cyc();
      ok = (bus.READY === 1'b1);
    end
    bus.ADDR_DATA = a;
    bus.ACK_ADDR  = 1'b1;
    cyc();
    bus.ACK_ADDR  = 1'b0;
    bus.ADDR_DATA = 32'h0;
  endtask

  task automatic wait_first(output int lat);
    lat = 0;
    while (bus.ACK_DATA_MEM === 4'hF && lat < 20) begin
      cyc();
      lat++;
    end
  endtask

  // Capture n words into d/ix starting at slot s, echoing each index once.
  task automatic collect(input int n, input int s);
    for (int i = 0; i < n; i++) begin
      d[s+i]  = bus.RDATA;
      ix[s+i] = bus.ACK_DATA_MEM;
      bus.ACK_DATA_L1 = bus.ACK_DATA_MEM;
      cyc();
      bus.ACK_DATA_L1 = 4'hF;
    end
  endtask

  task automatic finish_txn();
    bus.VALID = 1'b0;
    bus.STORE = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc();
    cyc();
    checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.READY); end
    checks++; if (bus.RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.RDATA); end
    checks++; if (bus.ACK_DATA_MEM !== 4'hF) begin errors++; $display("FAIL reset_ack got=%h exp=f", bus.ACK_DATA_MEM); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    RST = 1'b0;
    cyc();
  endtask

  task automatic test_load();
    bit ok;
    int lat;
    logic [3:0] k;
    start_txn(32'h13, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL load_grant got=%b exp=1", ok); end
    checks++; if (bus.READY !== 1'b1) begin errors++; $display("FAIL load_ready got=%b exp=1", bus.READY); end
    wait_first(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL load_latency got=%0d exp=4", lat); end
    collect(8, 0);
    for (int i = 0; i < 8; i++) begin
      k = exp_k(3'd3, i);
      checks++; if (ix[i] !== k) begin errors++; $display("FAIL load_idx[%0d] got=%h exp=%h", i, ix[i], k); end
      checks++; if (d[i] !== 32'h10 + 32'(k)) begin errors++; $display("FAIL load_data[%0d] got=%h exp=%h", i, d[i], 32'h10 + 32'(k)); end
    end
    checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL load_end_ready got=%b exp=0", bus.READY); end
    checks++; if (bus.ACK_DATA_MEM !== 4'hF) begin errors++; $display("FAIL load_end_ack got=%h exp=f", bus.ACK_DATA_MEM); end
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL load_done_busy got=%b exp=1", bus.BUSY); end
    finish_txn();
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL load_idle_busy got=%b exp=0", bus.BUSY); end
  endtask

  task automatic test_store_load();
    bit ok;
    int lat;
    logic [3:0] k;
    logic [31:0] e;
    start_txn(32'h25, 1'b1, ok);
    checks++; if (bus.ACK_DATA_MEM !== 4'h0) begin errors++; $display("FAIL store_req got=%h exp=0", bus.ACK_DATA_MEM); end
    checks++; if (bus.READY !== 1'b1) begin errors++; $display("FAIL store_ready got=%b exp=1", bus.READY); end
    bus.ADDR_DATA   = 32'hDEADBEEF;
    bus.ACK_DATA_L1 = 4'h0;
    cyc();
    bus.ACK_DATA_L1 = 4'hF;
    bus.ADDR_DATA   = 32'h0;
    checks++; if (bus.ACK_DATA_MEM !== 4'hF) begin errors++; $display("FAIL store_end_ack got=%h exp=f", bus.ACK_DATA_MEM); end
    checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL store_end_ready got=%b exp=0", bus.READY); end
    finish_txn();
    start_txn(32'h20, 1'b0, ok);
    wait_first(lat);
    collect(8, 0);
    for (int i = 0; i < 8; i++) begin
      k = exp_k(3'd0, i);
      e = (k == 4'd5) ? 32'hDEADBEEF : 32'h20 + 32'(k);
      checks++; if (d[i] !== e) begin errors++; $display("FAIL st_ld_data[%0d] got=%h exp=%h", i, d[i], e); end
    end
    finish_txn();
  endtask

  task automatic test_stall();
    bit ok;
    int lat;
    start_txn(32'h40, 1'b0, ok);
    wait_first(lat);
    collect(2, 0);
    bus.ACK_DATA_L1 = 4'h3;
    for (int c = 0; c < 5; c++) begin
      cyc();
      checks++; if (bus.ACK_DATA_MEM !== 4'h2) begin errors++; $display("FAIL stall_idx c%0d got=%h exp=2", c, bus.ACK_DATA_MEM); end
      checks++; if (bus.RDATA !== 32'h42) begin errors++; $display("FAIL stall_data c%0d got=%h exp=42", c, bus.RDATA); end
    end
    bus.ACK_DATA_L1 = 4'hF;
    collect(6, 2);
    for (int i = 0; i < 8; i++) begin
      checks++; if (ix[i] !== 4'(i) || d[i] !== 32'h40 + 32'(i)) begin
        errors++; $display("FAIL stall_word[%0d] got=%h/%h exp=%h/%h", i, ix[i], d[i], i, 32'h40 + 32'(i));
      end
    end
    finish_txn();
  endtask

  task automatic test_abort();
    bit ok;
    int lat;
    logic [3:0] k;
    start_txn(32'h80, 1'b0, ok);
    wait_first(lat);
    collect(4, 0);
    checks++; if (bus.ACK_DATA_MEM !== 4'h4) begin errors++; $display("FAIL abort_at_k4 got=%h exp=4", bus.ACK_DATA_MEM); end
    bus.VALID = 1'b0;
    cyc();
    checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", bus.READY); end
    checks++; if (bus.ACK_DATA_MEM !== 4'hF) begin errors++; $display("FAIL abort_ack got=%h exp=f", bus.ACK_DATA_MEM); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.BUSY); end
    start_txn(32'h30, 1'b0, ok);
    wait_first(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL abort_reload_lat got=%0d exp=4", lat); end
    collect(8, 0);
    for (int i = 0; i < 8; i++) begin
      k = exp_k(3'd0, i);
      checks++; if (ix[i] !== k || d[i] !== 32'h30 + 32'(k)) begin
        errors++; $display("FAIL abort_reload[%0d] got=%h/%h exp=%h/%h", i, ix[i], d[i], k, 32'h30 + 32'(k));
      end
    end
    finish_txn();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    start_txn(32'h50, 1'b0, ok);
    cyc();
    RST = 1'b1;
    cyc();
    checks++; if (bus.READY !== 1'b0 || bus.RDATA !== 32'h0 || bus.ACK_DATA_MEM !== 4'hF || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL rst_wait got=%b/%h/%h/%b exp=0/0/f/0", bus.READY, bus.RDATA, bus.ACK_DATA_MEM, bus.BUSY);
    end
    RST = 1'b0;
    bus.VALID = 1'b0;
    cyc();
    start_txn(32'h66, 1'b1, ok);
    checks++; if (bus.ACK_DATA_MEM !== 4'h0) begin errors++; $display("FAIL rst_st_req got=%h exp=0", bus.ACK_DATA_MEM); end
    bus.ADDR_DATA = 32'h12345678;
    cyc();
    RST = 1'b1;
    cyc();
    checks++; if (bus.READY !== 1'b0 || bus.RDATA !== 32'h0 || bus.ACK_DATA_MEM !== 4'hF || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL rst_store got=%b/%h/%h/%b exp=0/0/f/0", bus.READY, bus.RDATA, bus.ACK_DATA_MEM, bus.BUSY);
    end
    RST = 1'b0;
    bus.VALID = 1'b0;
    bus.STORE = 1'b0;
    bus.ADDR_DATA = 32'h0;
    cyc();
    start_txn(32'h60, 1'b0, ok);
    wait_first(lat);
    collect(8, 0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (d[i] !== 32'h60 + 32'(ix[i]) || ix[i] !== exp_k(3'd0, i)) begin
        errors++; $display("FAIL rst_unchanged[%0d] got=%h/%h exp=%h/%h", i, ix[i], d[i], exp_k(3'd0, i), 32'h60 + 32'(exp_k(3'd0, i)));
      end
    end
    finish_txn();
  endtask

  task automatic test_early_addr();
    int lat;
    logic [3:0] k;
    // VALID and ACK_ADDR together in IDLE; upper address bits alias away.
    bus.VALID     = 1'b1;
    bus.STORE     = 1'b0;
    bus.ACK_ADDR  = 1'b1;
    bus.ADDR_DATA = 32'h0000_1009;
    cyc();
    checks++; if (bus.READY !== 1'b1 || bus.ACK_DATA_MEM !== 4'hF) begin
      errors++; $display("FAIL early_grant got=%b/%h exp=1/f", bus.READY, bus.ACK_DATA_MEM);
    end
    cyc();
    bus.ACK_ADDR  = 1'b0;
    bus.ADDR_DATA = 32'h0;
    wait_first(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL early_latency got=%0d exp=4", lat); end
    collect(8, 0);
    for (int i = 0; i < 8; i++) begin
      k = exp_k(3'd1, i);
      checks++; if (ix[i] !== k || d[i] !== 32'h08 + 32'(k)) begin
        errors++; $display("FAIL early_word[%0d] got=%h/%h exp=%h/%h", i, ix[i], d[i], k, 32'h08 + 32'(k));
      end
    end
    finish_txn();
  endtask

  task automatic test_critical_word();
    bit ok;
    int lat;
    logic [3:0] k;
    start_txn(32'h0E, 1'b0, ok);
    wait_first(lat);
    collect(8, 0);
    for (int i = 0; i < 8; i++) begin
      k = exp_k(3'd6, i);
      checks++; if (ix[i] !== k || d[i] !== 32'h08 + 32'(k)) begin
        errors++; $display("FAIL cwf_word[%0d] got=%h/%h exp=%h/%h", i, ix[i], d[i], k, 32'h08 + 32'(k));
      end
    end
    finish_txn();
  endtask

  initial begin
    bus.VALID       = 1'b0;
    bus.STORE       = 1'b0;
    bus.ADDR_DATA   = 32'h0;
    bus.ACK_ADDR    = 1'b0;
    bus.ACK_DATA_L1 = 4'hF;
    for (int i = 0; i < 4096; i++) dut.u_array.mem[i] = 32'(i);
    @(negedge CLK);
    test_reset();
    test_load();
    test_store_load();
    test_stall();
    test_abort();
    test_reset_mid();
    test_early_addr();
    test_critical_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
